// File: rtl/fma_pkg.sv
// Shared constants for the FMA datapath: sign-code encodings and the default sum width.
package fma_pkg;

  // two_en encodings: bit0 = sign_P, bit1 = sign_C
  localparam logic [1:0] TWO_PP = 2'b00;  // +P +C
  localparam logic [1:0] TWO_NP = 2'b01;  // -P +C
  localparam logic [1:0] TWO_PN = 2'b10;  // +P -C
  localparam logic [1:0] TWO_NN = 2'b11;  // -P -C

  // Width of the product and aligned-addend magnitudes
  localparam int unsigned FMA_SUM_W = 74;

endpackage

// File: rtl/fma_cond_negate.sv
// Conditional two's-complement negation: y = neg ? -a : a.
module fma_cond_negate #(
  parameter int unsigned N = 8
) (
  input  logic         neg,
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);

  // Invert-and-increment only when negation is requested
  always_comb begin
    y = a;
    if (neg) begin
      y = (~a) + {{(N-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fma_sign_resolve.sv
// Two-stage sign-resolution stage of the FMA datapath. Stage 1 forms the signed sum of the
// conditionally negated product and addend; stage 2 converts it back to sign-magnitude with a
// zero flag. Valid/ready handshaking on both sides, full throughput, outputs registered.
module fma_sign_resolve
  import fma_pkg::*;
#(
  parameter int unsigned W = FMA_SUM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   two_en,
  input  logic [W-1:0] mag_p,
  input  logic [W-1:0] mag_c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   sum_mag,
  output logic         sum_sign,
  output logic         sum_zero
);

  // ---------------------------------------------------------------------------
  // Sign-code decode
  // ---------------------------------------------------------------------------
  logic neg_p, neg_c, eff_sub, both_neg;

  // Only an effective subtraction negates an operand; ++ and -- add magnitudes
  always_comb begin
    neg_p    = 1'b0;
    neg_c    = 1'b0;
    eff_sub  = 1'b0;
    both_neg = 1'b0;
    unique case (two_en)
      TWO_PP: ;
      TWO_NP: begin
        neg_p   = 1'b1;
        eff_sub = 1'b1;
      end
      TWO_PN: begin
        neg_c   = 1'b1;
        eff_sub = 1'b1;
      end
      TWO_NN: begin
        neg_p    = 1'b1;
        neg_c    = 1'b1;
        both_neg = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic s2_adv, s1_adv, accept;

  // Stage 2 can take a beat when empty or when its beat leaves this cycle
  always_comb begin
    s2_adv   = !out_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_adv;
    in_ready = !s1_valid_q || s2_adv;
    accept   = in_valid && in_ready;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: signed sum in W+2 bits
  // ---------------------------------------------------------------------------
  logic [W+1:0] op_p_ext, op_c_ext;
  logic [W+1:0] op_p_sgn, op_c_sgn;
  logic [W+1:0] s1_sum_q, s1_sum_d;
  logic         s1_both_neg_q, s1_both_neg_d;

  // Zero-extend so the sign bit is free and P+C cannot overflow
  always_comb begin
    op_p_ext = {2'b00, mag_p};
    op_c_ext = {2'b00, mag_c};
  end

  fma_cond_negate #(
    .N (W + 2)
  ) u_neg_p (
    .neg (neg_p && eff_sub),
    .a   (op_p_ext),
    .y   (op_p_sgn)
  );

  fma_cond_negate #(
    .N (W + 2)
  ) u_neg_c (
    .neg (neg_c && eff_sub),
    .a   (op_c_ext),
    .y   (op_c_sgn)
  );

  // Stage 1 next state: load on accept, drain on advance, otherwise hold
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_sum_d      = s1_sum_q;
    s1_both_neg_d = s1_both_neg_q;
    if (accept) begin
      s1_valid_d    = 1'b1;
      s1_sum_d      = op_p_sgn + op_c_sgn;
      s1_both_neg_d = both_neg;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_sum_q      <= '0;
      s1_both_neg_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_sum_q      <= s1_sum_d;
      s1_both_neg_q <= s1_both_neg_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: back to sign-magnitude
  // ---------------------------------------------------------------------------
  logic         s1_neg;
  logic [W:0]   s1_mag;
  logic [W:0]   sum_mag_q, sum_mag_d;
  logic         sum_sign_q, sum_sign_d;
  logic         sum_zero_q, sum_zero_d;

  always_comb begin
    s1_neg = s1_sum_q[W+1];
  end

  // |sum| < 2^W whenever the sum is negative, so W+1 bits suffice for the magnitude
  fma_cond_negate #(
    .N (W + 1)
  ) u_neg_mag (
    .neg (s1_neg),
    .a   (s1_sum_q[W:0]),
    .y   (s1_mag)
  );

  // Exact zero takes -0 only for the -P-C code, +0 otherwise
  always_comb begin
    out_valid_d = out_valid_q;
    sum_mag_d   = sum_mag_q;
    sum_sign_d  = sum_sign_q;
    sum_zero_d  = sum_zero_q;
    if (s1_adv) begin
      out_valid_d = 1'b1;
      sum_mag_d   = s1_mag;
      sum_zero_d  = (s1_mag == '0);
      sum_sign_d  = (s1_mag == '0) ? s1_both_neg_q : (s1_both_neg_q || s1_neg);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_mag_q   <= '0;
      sum_sign_q  <= 1'b0;
      sum_zero_q  <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      sum_mag_q   <= sum_mag_d;
      sum_sign_q  <= sum_sign_d;
      sum_zero_q  <= sum_zero_d;
    end
  end

  always_comb begin
    out_valid = out_valid_q;
    sum_mag   = sum_mag_q;
    sum_sign  = sum_sign_q;
    sum_zero  = sum_zero_q;
  end

endmodule

// File: tb/tb_fma_sign_resolve.sv
// Scoreboard bench for fma_sign_resolve: directed vectors, expected results queued on accept,
// monitor pops and compares on every output transfer and checks stability during stalls.
module tb_fma_sign_resolve;

  localparam int unsigned W = 74;

  typedef struct packed {
    logic [W:0] mag;
    logic       sign;
    logic       zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   two_en = 2'b00;
  logic [W-1:0] mag_p = '0;
  logic [W-1:0] mag_c = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W:0]   sum_mag;
  logic         sum_sign;
  logic         sum_zero;

  int   checks = 0;
  int   failures = 0;
  int   n_acc = 0;
  exp_t sb[$];

  logic [W-1:0] all1;
  logic [W:0]   two_max;
  logic [W:0]   max_ext;

  always #5 clk = ~clk;

  fma_sign_resolve #(
    .W (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .two_en    (two_en),
    .mag_p     (mag_p),
    .mag_c     (mag_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_mag   (sum_mag),
    .sum_sign  (sum_sign),
    .sum_zero  (sum_zero)
  );

  task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one beat starting at posedge+1; queue its expected result when it is accepted
  task automatic send(input logic [1:0] te, input logic [W-1:0] p, input logic [W-1:0] c,
                      input logic [W:0] em, input logic es, input logic ez);
    bit done = 0;
    in_valid = 1'b1;
    two_en   = te;
    mag_p    = p;
    mag_c    = c;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{mag: em, sign: es, zero: ez});
        n_acc++;
        done = 1;
      end
      @(posedge clk);
      #1;
      if (done) break;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: actual=in_ready_low required=accept");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check(name, sb.size(), 0);
  endtask

  // Monitor: compare every transfer against the scoreboard, check holding during stalls
  logic       stalled = 1'b0;
  logic [W:0] held_mag;
  logic       held_sign, held_zero;

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (out_valid && !out_ready) begin
        if (stalled) begin
          check("stall_mag", sum_mag, held_mag);
          check("stall_sign", sum_sign, held_sign);
          check("stall_zero", sum_zero, held_zero);
        end
        stalled   = 1'b1;
        held_mag  = sum_mag;
        held_sign = sum_sign;
        held_zero = sum_zero;
      end else begin
        stalled = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: actual=mag %0h required=no beat", sum_mag);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_mag", sum_mag, e.mag);
          check("out_sign", sum_sign, e.sign);
          check("out_zero", sum_zero, e.zero);
        end
      end
    end
  end

  initial begin
    all1    = '1;
    two_max = {all1, 1'b0};
    max_ext = {1'b0, all1};

    // Reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum_mag", sum_mag, 0);
    check("rst_sum_sign", sum_sign, 0);
    check("rst_sum_zero", sum_zero, 1);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Latency: single beat, out_valid exactly 2 cycles after accept
    send(2'b00, 74'd5, 74'd3, 75'd8, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("lat_cycle1", out_valid, 0);
    @(negedge clk);
    check("lat_cycle2", out_valid, 1);
    @(posedge clk);
    #1;

    // Directed sign cases, streamed back to back
    send(2'b01, 74'd5, 74'd3, 75'd2, 1'b1, 1'b0);
    send(2'b10, 74'd5, 74'd3, 75'd2, 1'b0, 1'b0);
    send(2'b01, 74'd7, 74'd7, 75'd0, 1'b0, 1'b1);
    send(2'b11, 74'd0, 74'd0, 75'd0, 1'b1, 1'b1);
    send(2'b10, 74'd9, 74'd9, 75'd0, 1'b0, 1'b1);
    send(2'b00, 74'd0, 74'd0, 75'd0, 1'b0, 1'b1);
    send(2'b00, all1, all1, two_max, 1'b0, 1'b0);
    send(2'b11, 74'd5, 74'd3, 75'd8, 1'b1, 1'b0);
    send(2'b10, 74'd3, 74'd5, 75'd2, 1'b1, 1'b0);
    send(2'b01, 74'd3, 74'd5, 75'd2, 1'b0, 1'b0);
    send(2'b10, 74'd0, all1, max_ext, 1'b1, 1'b0);
    send(2'b01, all1, 74'd1, {1'b0, all1} - 75'd1, 1'b1, 1'b0);
    send(2'b11, all1, all1, two_max, 1'b1, 1'b0);
    idle();
    drain("drain_directed");

    // Back-pressure: 4 beats with out_ready low, only 2 fit
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_acc     = 0;
    fork
      begin
        send(2'b00, 74'd1, 74'd1, 75'd2, 1'b0, 1'b0);
        send(2'b10, 74'd10, 74'd4, 75'd6, 1'b0, 1'b0);
        send(2'b01, 74'd10, 74'd4, 75'd6, 1'b1, 1'b0);
        send(2'b11, 74'd2, 74'd2, 75'd4, 1'b1, 1'b0);
        idle();
      end
      begin
        repeat (5) @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_accepted", n_acc, 2);
        check("bp_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        // Full throughput once released: a transfer on each of the next 4 cycles
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("bp_stream_valid", out_valid, 1);
        end
      end
    join
    drain("drain_bp");

    // Reset with 2 beats in flight: both must vanish
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(2'b00, 74'd100, 74'd1, 75'd101, 1'b0, 1'b0);
    send(2'b10, 74'd50, 74'd1, 75'd49, 1'b0, 1'b0);
    in_valid = 1'b1;
    two_en   = 2'b00;
    mag_p    = 74'd77;
    mag_c    = 74'd77;
    rst      = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_sum_zero", sum_zero, 1);
    check("flush_sum_mag", sum_mag, 0);
    check("flush_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("flush_no_output", out_valid, 0);
    @(posedge clk);
    #1;

    // Recovery after reset
    send(2'b00, 74'd9, 74'd9, 75'd18, 1'b0, 1'b0);
    idle();
    drain("drain_recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if something wedges beyond every bounded wait
  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
